// File: rtl/fifo_addr_ctrl_pkg.sv
// Shared defaults for the FIFO pointer controller.
package fifo_addr_ctrl_pkg;

  localparam int unsigned DefFifoDepth = 16;
  localparam int unsigned DefCntWidth  = 8;

endpackage

// File: rtl/fifo_addr_ctrl_ptr_counter.sv
// Extended-width pointer counter: enable, synchronous clear, async reset, binary rollover.
module fifo_addr_ctrl_ptr_counter #(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fifo_addr_ctrl.sv
// Read/write pointer controller with sticky overflow/underflow flags.
// Saturating error counters are built only when SYNC_FIFO_ERR_CNT_EN is defined.
module fifo_addr_ctrl
  import fifo_addr_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  parameter int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH)
`ifdef SYNC_FIFO_ERR_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid_s,
  input  logic                  i_ready_m,
  input  logic                  i_full,
  input  logic                  i_empty,
  input  logic                  i_flush,
  output logic                  o_wr_en,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH:0]   o_wr_addr,
  output logic [ADDR_WIDTH:0]   o_rd_addr,
  output logic                  o_overflow,
  output logic                  o_underflow
`ifdef SYNC_FIFO_ERR_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  o_ovf_cnt,
  output logic [CNT_WIDTH-1:0]  o_udf_cnt
`endif
);

  localparam int unsigned PtrWidth = ADDR_WIDTH + 1;

  logic wr_refused, rd_refused;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Flags come from registered pointers only, so these strobes form no loop.
  assign o_wr_en    = i_valid_s & ~i_full & ~i_flush;
  assign o_rd_en    = i_ready_m & ~i_empty & ~i_flush;
  assign wr_refused = i_valid_s & i_full & ~i_flush;
  assign rd_refused = i_ready_m & i_empty & ~i_flush;

  fifo_addr_ctrl_ptr_counter #(
    .Width (PtrWidth)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (o_wr_en),
    .clr_i (i_flush),
    .cnt_o (o_wr_addr)
  );

  fifo_addr_ctrl_ptr_counter #(
    .Width (PtrWidth)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .en_i  (o_rd_en),
    .clr_i (i_flush),
    .cnt_o (o_rd_addr)
  );

  always_comb begin
    overflow_d  = overflow_q | wr_refused;
    underflow_d = underflow_q | rd_refused;
    if (i_flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;

`ifdef SYNC_FIFO_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_WIDTH-1:0] udf_cnt_q, udf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    udf_cnt_d = udf_cnt_q;
    if (i_flush) begin
      ovf_cnt_d = '0;
      udf_cnt_d = '0;
    end else begin
      if (wr_refused && (ovf_cnt_q != {CNT_WIDTH{1'b1}})) begin
        ovf_cnt_d = ovf_cnt_q + CNT_WIDTH'(1);
      end
      if (rd_refused && (udf_cnt_q != {CNT_WIDTH{1'b1}})) begin
        udf_cnt_d = udf_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      udf_cnt_q <= udf_cnt_d;
    end
  end

  assign o_ovf_cnt = ovf_cnt_q;
  assign o_udf_cnt = udf_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_addr_ctrl.sv
// Scoreboard bench for fifo_addr_ctrl; the reference model tracks occupancy as plain counts.
module tb_fifo_addr_ctrl;

  localparam int Depth   = 16;
  localparam int PtrMod  = 2 * Depth;
  localparam int CntMax  = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid_s, i_ready_m, i_full, i_empty, i_flush;
  logic       o_wr_en, o_rd_en;
  logic [4:0] o_wr_addr, o_rd_addr;
  logic       o_overflow, o_underflow;
`ifdef SYNC_FIFO_ERR_CNT_EN
  logic [7:0] o_ovf_cnt, o_udf_cnt;
`endif

  always #5 clk = ~clk;

  fifo_addr_ctrl #(
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid_s   (i_valid_s),
    .i_ready_m   (i_ready_m),
    .i_full      (i_full),
    .i_empty     (i_empty),
    .i_flush     (i_flush),
    .o_wr_en     (o_wr_en),
    .o_rd_en     (o_rd_en),
    .o_wr_addr   (o_wr_addr),
    .o_rd_addr   (o_rd_addr),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
`ifdef SYNC_FIFO_ERR_CNT_EN
    ,
    .o_ovf_cnt   (o_ovf_cnt),
    .o_udf_cnt   (o_udf_cnt)
`endif
  );

  typedef struct {
    int wr_en;
    int rd_en;
    int wr_ptr;
    int rd_ptr;
    int ovf;
    int udf;
    int ovf_cnt;
    int udf_cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: total writes/reads accepted since the last clear.
  int m_wr = 0, m_rd = 0, m_ovf = 0, m_udf = 0, m_oc = 0, m_uc = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // One cycle: drive inputs just after the edge, queue the expected view, advance the model.
  task automatic step(input logic v, input logic r, input logic f, input logic rs);
    exp_t e;
    int   occ;
    logic full, empty;
    if (rs) begin
      m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0; m_oc = 0; m_uc = 0;
    end
    occ   = m_wr - m_rd;
    full  = (occ == Depth - 1);
    empty = (occ == 0);
    rst       = rs;
    i_valid_s = v;
    i_ready_m = r;
    i_flush   = f;
    i_full    = full;
    i_empty   = empty;
    e.wr_en   = (v && !full && !f) ? 1 : 0;
    e.rd_en   = (r && !empty && !f) ? 1 : 0;
    e.wr_ptr  = m_wr % PtrMod;
    e.rd_ptr  = m_rd % PtrMod;
    e.ovf     = m_ovf;
    e.udf     = m_udf;
    e.ovf_cnt = m_oc;
    e.udf_cnt = m_uc;
    sb.push_back(e);
    if (!rs) begin
      if (f) begin
        m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0; m_oc = 0; m_uc = 0;
      end else begin
        if (e.wr_en == 1) m_wr++;
        if (e.rd_en == 1) m_rd++;
        if (v && full) begin
          m_ovf = 1;
          if (m_oc < CntMax) m_oc++;
        end
        if (r && empty) begin
          m_udf = 1;
          if (m_uc < CntMax) m_uc++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: each negedge, compare the DUT against the entry queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_en", int'(o_wr_en), e.wr_en);
        chk("rd_en", int'(o_rd_en), e.rd_en);
        chk("wr_addr", int'(o_wr_addr), e.wr_ptr);
        chk("rd_addr", int'(o_rd_addr), e.rd_ptr);
        chk("overflow", int'(o_overflow), e.ovf);
        chk("underflow", int'(o_underflow), e.udf);
`ifdef SYNC_FIFO_ERR_CNT_EN
        chk("ovf_cnt", int'(o_ovf_cnt), e.ovf_cnt);
        chk("udf_cnt", int'(o_udf_cnt), e.udf_cnt);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pv, pr;
    rst = 1'b1; i_valid_s = 1'b0; i_ready_m = 1'b0; i_flush = 1'b0;
    i_full = 1'b0; i_empty = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);                       // read on empty
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0);  // fill, 16th refused
    step(1'b1, 1'b1, 1'b0, 1'b0);                       // full with both requests
    step(1'b1, 1'b1, 1'b1, 1'b0);                       // flush with both requests
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);                       // reset mid-stream at wr=7, rd=2
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);                       // occupancy 4, both advance
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, 1'b0);  // pointers wrap past 31
    pv = 50; pr = 50;
    for (int i = 0; i < 2400; i++) begin
      if ((i % 200) == 0) begin
        pv = $urandom_range(10, 95);
        pr = $urandom_range(10, 95);
      end
      step(($urandom_range(0, 99) < pv), ($urandom_range(0, 99) < pr),
           ($urandom_range(0, 255) == 0), (i == 1234));
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
